// File: rtl/main_control_fsm_pkg.sv
// ---------------------------------------------------------------------------
// main_control_fsm_pkg
// Shared definitions for the multi-cycle main control FSM:
//   - 4-bit state encodings (legacy-compatible constants)
//   - opcode and funct field constants
//   - aluControl / aluSrcB / PCSource encodings
//   - helper identifying states that end an instruction
// ---------------------------------------------------------------------------
package main_control_fsm_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_FETCH   = 4'd0;
    localparam state_t S_DECODE  = 4'd1;
    localparam state_t S_MEMADR  = 4'd2;
    localparam state_t S_MEMRD   = 4'd3;
    localparam state_t S_MEMWB   = 4'd4;
    localparam state_t S_MEMWR   = 4'd5;
    localparam state_t S_EXEC    = 4'd6;
    localparam state_t S_ALUWB   = 4'd7;
    localparam state_t S_ADDIEX  = 4'd8;
    localparam state_t S_ADDIWB  = 4'd9;
    localparam state_t S_BRANCH  = 4'd10;
    localparam state_t S_JUMP    = 4'd11;
    localparam state_t S_ILLEGAL = 4'd12;
    localparam state_t S_INTR    = 4'd13;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_ZERO   = 2'b11;

    // States after which the next instruction boundary is reached.
    function automatic logic is_terminal(input state_t s);
        case (s)
            S_MEMWB, S_MEMWR, S_ALUWB, S_ADDIWB,
            S_BRANCH, S_JUMP, S_ILLEGAL: is_terminal = 1'b1;
            default:                     is_terminal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/main_control_fsm_alu_decoder.sv
// ---------------------------------------------------------------------------
// alu_decoder
// Combinational map from the R-type funct field to the ALU operation.
//   i_funct        : funct field of the instruction register
//   o_alu_control  : ALU operation (ADD when funct is unsupported)
//   o_valid        : 1 when funct is a supported R-type operation
// ---------------------------------------------------------------------------
module alu_decoder
    import main_control_fsm_pkg::*;
(
    input  logic [5:0] i_funct,
    output logic [1:0] o_alu_control,
    output logic       o_valid
);

    always_comb begin
        o_alu_control = ALU_ADD;
        o_valid       = 1'b1;
        case (i_funct)
            FN_ADD:  o_alu_control = ALU_ADD;
            FN_SUB:  o_alu_control = ALU_SUB;
            FN_AND:  o_alu_control = ALU_AND;
            FN_OR:   o_alu_control = ALU_OR;
            default: o_valid       = 1'b0;
        endcase
    end

endmodule

// File: rtl/main_control_fsm.sv
// ---------------------------------------------------------------------------
// main_control_fsm
// Moore control FSM for a multi-cycle MIPS-like datapath with a single
// level-sensitive interrupt taken only at instruction boundaries.
//   clk, reset      : clock, synchronous active-high reset
//   op, funct       : opcode / function fields of the instruction register
//   irq             : interrupt request (level)
//   PCWrite .. isInterrupted : 1-bit datapath controls
//   aluSrcB, aluControl, PCSource : 2-bit datapath selects
//   irq_ack         : pulses in the interrupt-entry cycle
//   illegal_op      : pulses in the illegal-instruction cycle
//   state_dbg       : current state encoding
// ---------------------------------------------------------------------------
module main_control_fsm
    import main_control_fsm_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       irq,
    output logic       PCWrite,
    output logic       isBranch,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       lorD,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       ALUSrcA,
    output logic       isInterrupted,
    output logic [1:0] aluSrcB,
    output logic [1:0] aluControl,
    output logic [1:0] PCSource,
    output logic       irq_ack,
    output logic       illegal_op,
    output logic [3:0] state_dbg
);

    state_t     r_state;
    logic       r_int_mask;
    state_t     w_next_state;
    logic       w_mask_eff;
    logic [1:0] w_fn_alu_control;
    logic       w_fn_valid;

    alu_decoder u_alu_decoder (
        .i_funct       (funct),
        .o_alu_control (w_fn_alu_control),
        .o_valid       (w_fn_valid)
    );

    // The JUMP that returns from the handler re-opens interrupts at its own
    // boundary, so a request pending on return is taken immediately.
    assign w_mask_eff = r_int_mask && (r_state != S_JUMP);

    always_comb begin
        w_next_state = S_FETCH;
        if (is_terminal(r_state)) begin
            w_next_state = (irq && !w_mask_eff) ? S_INTR : S_FETCH;
        end else begin
            case (r_state)
                S_FETCH, S_INTR: w_next_state = S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_LW, OP_SW: w_next_state = S_MEMADR;
                        OP_RTYPE:     w_next_state = S_EXEC;
                        OP_BEQ:       w_next_state = S_BRANCH;
                        OP_ADDI:      w_next_state = S_ADDIEX;
                        OP_J:         w_next_state = S_JUMP;
                        default:      w_next_state = S_ILLEGAL;
                    endcase
                end
                S_MEMADR: w_next_state = (op == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:  w_next_state = S_MEMWB;
                S_EXEC:   w_next_state = w_fn_valid ? S_ALUWB : S_ILLEGAL;
                S_ADDIEX: w_next_state = S_ADDIWB;
                default:  w_next_state = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_FETCH;
            r_int_mask <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_next_state == S_INTR) begin
                r_int_mask <= 1'b1;
            end else if (r_state == S_JUMP) begin
                r_int_mask <= 1'b0;
            end
        end
    end

    // Outputs decode the state register; reset forces every output low in
    // the same cycle so an abandoned instruction never writes.
    always_comb begin
        PCWrite       = 1'b0;
        isBranch      = 1'b0;
        IRWrite       = 1'b0;
        MemWrite      = 1'b0;
        RegWrite      = 1'b0;
        lorD          = 1'b0;
        MemtoReg      = 1'b0;
        RegDst        = 1'b0;
        ALUSrcA       = 1'b0;
        isInterrupted = 1'b0;
        aluSrcB       = SRCB_REG;
        aluControl    = ALU_ADD;
        PCSource      = PCSRC_ALU;
        irq_ack       = 1'b0;
        illegal_op    = 1'b0;
        state_dbg     = r_state;
        case (r_state)
            S_FETCH: begin
                IRWrite = 1'b1;
                aluSrcB = SRCB_FOUR;
                PCWrite = 1'b1;
            end
            S_DECODE: aluSrcB = SRCB_BRANCH;
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                aluSrcB = SRCB_IMM;
            end
            S_MEMRD: lorD = 1'b1;
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEMWR: begin
                lorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA    = 1'b1;
                aluSrcB    = SRCB_REG;
                aluControl = w_fn_alu_control;
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                aluSrcB = SRCB_IMM;
            end
            S_ADDIWB: RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                aluSrcB    = SRCB_REG;
                aluControl = ALU_SUB;
                isBranch   = 1'b1;
                PCSource   = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                PCSource = PCSRC_JUMP;
                PCWrite  = 1'b1;
            end
            S_ILLEGAL: illegal_op = 1'b1;
            S_INTR: begin
                isInterrupted = 1'b1;
                IRWrite       = 1'b1;
                aluSrcB       = SRCB_FOUR;
                PCWrite       = 1'b1;
                irq_ack       = 1'b1;
            end
            default: ;
        endcase
        if (reset) begin
            PCWrite       = 1'b0;
            isBranch      = 1'b0;
            IRWrite       = 1'b0;
            MemWrite      = 1'b0;
            RegWrite      = 1'b0;
            lorD          = 1'b0;
            MemtoReg      = 1'b0;
            RegDst        = 1'b0;
            ALUSrcA       = 1'b0;
            isInterrupted = 1'b0;
            aluSrcB       = '0;
            aluControl    = '0;
            PCSource      = '0;
            irq_ack       = 1'b0;
            illegal_op    = 1'b0;
            state_dbg     = '0;
        end
    end

endmodule

// File: tb/tb_main_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_main_control_fsm
// Directed instruction sequences for main_control_fsm. Each stimulus cycle
// queues the hand-written expected output vector for that cycle; a monitor
// on the falling edge pops and compares against the DUT.
// ---------------------------------------------------------------------------
module tb_main_control_fsm;
    import main_control_fsm_pkg::*;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       irq;
    logic       PCWrite, isBranch, IRWrite, MemWrite, RegWrite, lorD;
    logic       MemtoReg, RegDst, ALUSrcA, isInterrupted;
    logic [1:0] aluSrcB, aluControl, PCSource;
    logic       irq_ack, illegal_op;
    logic [3:0] state_dbg;

    main_control_fsm dut (
        .clk           (clk),
        .reset         (reset),
        .op            (op),
        .funct         (funct),
        .irq           (irq),
        .PCWrite       (PCWrite),
        .isBranch      (isBranch),
        .IRWrite       (IRWrite),
        .MemWrite      (MemWrite),
        .RegWrite      (RegWrite),
        .lorD          (lorD),
        .MemtoReg      (MemtoReg),
        .RegDst        (RegDst),
        .ALUSrcA       (ALUSrcA),
        .isInterrupted (isInterrupted),
        .aluSrcB       (aluSrcB),
        .aluControl    (aluControl),
        .PCSource      (PCSource),
        .irq_ack       (irq_ack),
        .illegal_op    (illegal_op),
        .state_dbg     (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {state, PCWrite, isBranch, IRWrite, MemWrite, RegWrite, lorD, MemtoReg,
    //  RegDst, ALUSrcA, isInterrupted, aluSrcB, aluControl, PCSource,
    //  irq_ack, illegal_op}
    logic [21:0] act;
    assign act = {state_dbg, PCWrite, isBranch, IRWrite, MemWrite, RegWrite,
                  lorD, MemtoReg, RegDst, ALUSrcA, isInterrupted,
                  aluSrcB, aluControl, PCSource, irq_ack, illegal_op};

    typedef struct {
        logic [21:0] v;
        string       n;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [21:0] mk(
        input logic [3:0] st,
        input logic pcw, input logic br, input logic irw, input logic mw,
        input logic rw, input logic lord, input logic m2r, input logic rd,
        input logic asa, input logic intr,
        input logic [1:0] sb, input logic [1:0] ac, input logic [1:0] ps,
        input logic ack, input logic ill);
        mk = {st, pcw, br, irw, mw, rw, lord, m2r, rd, asa, intr,
              sb, ac, ps, ack, ill};
    endfunction

    logic [21:0] e_zero, e_fetch, e_decode, e_memadr, e_memrd, e_memwb;
    logic [21:0] e_memwr, e_exec_sub, e_exec_or, e_exec_bad, e_aluwb;
    logic [21:0] e_addiex, e_addiwb, e_branch, e_jump, e_illegal, e_intr;

    // Monitor: the DUT presents a control vector every cycle; compare it
    // whenever an expectation is pending.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (act !== e.v) begin
                errors++;
                $display("FAIL %s: got %h (state %0d) expected %h (state %0d)",
                         e.n, act, act[21:18], e.v, e.v[21:18]);
            end
        end
    end

    task automatic cyc(input logic r, input logic [5:0] o, input logic [5:0] f,
                       input logic q, input logic [21:0] e, input string n);
        @(posedge clk);
        #1;
        reset = r;
        op    = o;
        funct = f;
        irq   = q;
        exp_q.push_back('{v: e, n: n});
    endtask

    initial begin
        reset = 1'b1;
        op    = '0;
        funct = '0;
        irq   = 1'b0;

        //              st         pcw br irw mw rw lrd m2r rd asa int sb     ac     ps     ack ill
        e_zero     = '0;
        e_fetch    = mk(S_FETCH,   1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0);
        e_decode   = mk(S_DECODE,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0, 0);
        e_memadr   = mk(S_MEMADR,  0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b10, 2'b00, 2'b00, 0, 0);
        e_memrd    = mk(S_MEMRD,   0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
        e_memwb    = mk(S_MEMWB,   0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
        e_memwr    = mk(S_MEMWR,   0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
        e_exec_sub = mk(S_EXEC,    0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 2'b00, 0, 0);
        e_exec_or  = mk(S_EXEC,    0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b11, 2'b00, 0, 0);
        e_exec_bad = mk(S_EXEC,    0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0);
        e_aluwb    = mk(S_ALUWB,   0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
        e_addiex   = mk(S_ADDIEX,  0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b10, 2'b00, 2'b00, 0, 0);
        e_addiwb   = mk(S_ADDIWB,  0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
        e_branch   = mk(S_BRANCH,  0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 2'b01, 0, 0);
        e_jump     = mk(S_JUMP,    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 0, 0);
        e_illegal  = mk(S_ILLEGAL, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1);
        e_intr     = mk(S_INTR,    1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 1, 0);

        // Reset: all outputs low while held
        cyc(1, OP_LW, 6'd0, 0, e_zero, "reset0");
        cyc(1, OP_LW, 6'd0, 1, e_zero, "reset1");

        // lw: 5 cycles
        cyc(0, OP_LW, 6'd0, 0, e_fetch,  "lw_fetch");
        cyc(0, OP_LW, 6'd0, 0, e_decode, "lw_decode");
        cyc(0, OP_LW, 6'd0, 0, e_memadr, "lw_memadr");
        cyc(0, OP_LW, 6'd0, 0, e_memrd,  "lw_memrd");
        cyc(0, OP_LW, 6'd0, 0, e_memwb,  "lw_memwb");

        // R-type sub, then or
        cyc(0, OP_RTYPE, FN_SUB, 0, e_fetch,    "sub_fetch");
        cyc(0, OP_RTYPE, FN_SUB, 0, e_decode,   "sub_decode");
        cyc(0, OP_RTYPE, FN_SUB, 0, e_exec_sub, "sub_exec");
        cyc(0, OP_RTYPE, FN_SUB, 0, e_aluwb,    "sub_aluwb");
        cyc(0, OP_RTYPE, FN_OR,  0, e_fetch,    "or_fetch");
        cyc(0, OP_RTYPE, FN_OR,  0, e_decode,   "or_decode");
        cyc(0, OP_RTYPE, FN_OR,  0, e_exec_or,  "or_exec");
        cyc(0, OP_RTYPE, FN_OR,  0, e_aluwb,    "or_aluwb");

        // addi
        cyc(0, OP_ADDI, 6'd0, 0, e_fetch,  "addi_fetch");
        cyc(0, OP_ADDI, 6'd0, 0, e_decode, "addi_decode");
        cyc(0, OP_ADDI, 6'd0, 0, e_addiex, "addi_ex");
        cyc(0, OP_ADDI, 6'd0, 0, e_addiwb, "addi_wb");

        // beq and j
        cyc(0, OP_BEQ, 6'd0, 0, e_fetch,  "beq_fetch");
        cyc(0, OP_BEQ, 6'd0, 0, e_decode, "beq_decode");
        cyc(0, OP_BEQ, 6'd0, 0, e_branch, "beq_branch");
        cyc(0, OP_J,   6'd0, 0, e_fetch,  "j_fetch");
        cyc(0, OP_J,   6'd0, 0, e_decode, "j_decode");
        cyc(0, OP_J,   6'd0, 0, e_jump,   "j_jump");

        // Illegal opcode, then illegal funct
        cyc(0, 6'b111111, 6'd0, 0, e_fetch,   "illop_fetch");
        cyc(0, 6'b111111, 6'd0, 0, e_decode,  "illop_decode");
        cyc(0, 6'b111111, 6'd0, 0, e_illegal, "illop_illegal");
        cyc(0, OP_RTYPE, 6'b101010, 0, e_fetch,    "illfn_fetch");
        cyc(0, OP_RTYPE, 6'b101010, 0, e_decode,   "illfn_decode");
        cyc(0, OP_RTYPE, 6'b101010, 0, e_exec_bad, "illfn_exec");
        cyc(0, OP_RTYPE, 6'b101010, 0, e_illegal,  "illfn_illegal");

        // sw with irq dropped before the boundary: not taken
        cyc(0, OP_SW, 6'd0, 1, e_fetch,  "swirq_fetch");
        cyc(0, OP_SW, 6'd0, 1, e_decode, "swirq_decode");
        cyc(0, OP_SW, 6'd0, 0, e_memadr, "swirq_memadr");
        cyc(0, OP_SW, 6'd0, 0, e_memwr,  "swirq_memwr");

        // lw with irq raised in MEMRD: completes, then INTR
        cyc(0, OP_LW, 6'd0, 0, e_fetch,  "irq_lw_fetch");
        cyc(0, OP_LW, 6'd0, 0, e_decode, "irq_lw_decode");
        cyc(0, OP_LW, 6'd0, 0, e_memadr, "irq_lw_memadr");
        cyc(0, OP_LW, 6'd0, 1, e_memrd,  "irq_lw_memrd");
        cyc(0, OP_LW, 6'd0, 1, e_memwb,  "irq_lw_memwb");
        // handler body: addi, irq still high but masked
        cyc(0, OP_ADDI, 6'd0, 1, e_intr,   "irq_intr");
        cyc(0, OP_ADDI, 6'd0, 1, e_decode, "irq_h_decode");
        cyc(0, OP_ADDI, 6'd0, 1, e_addiex, "irq_h_addiex");
        cyc(0, OP_ADDI, 6'd0, 1, e_addiwb, "irq_h_addiwb");
        // masked boundary -> FETCH; handler returns with j
        cyc(0, OP_J, 6'd0, 1, e_fetch,  "mask_fetch");
        cyc(0, OP_J, 6'd0, 1, e_decode, "ret_decode");
        cyc(0, OP_J, 6'd0, 0, e_jump,   "ret_jump");
        // mask cleared: second irq taken after beq
        cyc(0, OP_BEQ, 6'd0, 0, e_fetch,  "irq2_fetch");
        cyc(0, OP_BEQ, 6'd0, 0, e_decode, "irq2_decode");
        cyc(0, OP_BEQ, 6'd0, 1, e_branch, "irq2_branch");
        cyc(0, OP_J,   6'd0, 0, e_intr,   "irq2_intr");
        cyc(0, OP_J,   6'd0, 0, e_decode, "irq2_decode2");
        cyc(0, OP_J,   6'd0, 0, e_jump,   "irq2_jump");

        // sw with reset asserted in MEMWR: no write, then FETCH
        cyc(0, OP_SW, 6'd0, 0, e_fetch,  "swrst_fetch");
        cyc(0, OP_SW, 6'd0, 0, e_decode, "swrst_decode");
        cyc(0, OP_SW, 6'd0, 0, e_memadr, "swrst_memadr");
        cyc(1, OP_SW, 6'd0, 0, e_zero,   "swrst_memwr_reset");
        cyc(0, OP_SW, 6'd0, 0, e_fetch,  "swrst_after");

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations expected 0",
                     exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
